lcd_text_feeder: RTL and testbench
==================================

Name: lcd_text_feeder

Overview:
- Upstream stage of the HD44780 LCD driver.
- Accepts a byte stream of characters from a producer over a valid/ready port and buffers it in a small FIFO.
- Tracks cursor position on a 2x16 display and auto-issues set-DDRAM-address commands at line wrap, newline and after clear.
- Drives the driver's lcd_enable/lcd_bus handshake: one command per transaction, paced by busy plus a fixed hold-off.

Parameters:
- DEPTH, 16: character FIFO entries (power of 2).
- HOLD_CYCLES, 1600: minimum clk cycles from an issue until the next issue; covers the driver's 50*clk_freq transaction window.
- CLR_CYCLES, 6000: hold-off after a display-clear command.
- CNT_W, 14: hold-off counter width; must hold CLR_CYCLES.
- COLS, 16: characters per line.

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- in_char  in  8  character byte from producer
- in_valid  in  1  in_char valid
- in_ready  out  1  FIFO can accept (=!full)
- clr_req  in  1  single-cycle request to clear display and home cursor
- busy  in  1  busy from LCD driver
- lcd_enable  out  1  one-cycle transaction strobe to driver
- lcd_bus  out  10  {rs, rw, data[7:0]} to driver
- cursor_col  out  4  current column 0..COLS-1
- cursor_line  out  1  current line 0/1
- idle  out  1  FIFO empty, nothing pending, FSM in IDLE

Behaviour:
- Reset (rst=1 at clk edge):
  - FSM to IDLE; FIFO emptied; lcd_enable=0; lcd_bus=0; cursor_col=0; cursor_line=0.
  - addr_pending=1; clr_pending=0; hold counter=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-transaction aborts immediately; no command is completed.
- FIFO: push on in_valid && in_ready. Pop only from a non-empty FIFO.
  - Full: push refused, even if a pop occurs the same cycle.
  - Empty: a same-cycle push is not visible to the pop.
- clr_req: sets clr_pending on any cycle and in any state. It stays set until the clear is issued. Multiple requests before issue collapse into one clear.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, when busy==0, selects by priority:
  - (1) clr_pending: command 0x001. Clear clr_pending; col=0, line=0, addr_pending=1; FIFO is not flushed.
  - (2) addr_pending: command {2'b00, 8'h80 | line<<6 | col}. Clear addr_pending.
  - (3) FIFO non-empty: pop the head.
    - 0x0A (newline): line toggles, col=0, addr_pending=1. No bus command; stay IDLE.
    - 0x0D (carriage return): col=0, addr_pending=1. No bus command; stay IDLE.
    - Other bytes: command {1'b1, 1'b0, char}. Then col+1. If col was COLS-1: col=0, line toggles, addr_pending=1.
  - When a command is selected: lcd_bus loads next cycle and the FSM moves to ISSUE.
  - When busy==1 or nothing is pending: stay IDLE, lcd_enable=0.
- ISSUE: lcd_enable=1 for exactly this one cycle. Load the hold counter with HOLD_CYCLES-1, or CLR_CYCLES-1 for a clear. Go to WAIT.
- WAIT:
  - lcd_enable=0; lcd_bus held stable throughout.
  - Counter decrements to 0. At 0 with busy==0, go to IDLE. At 0 with busy==1, remain in WAIT.
- Latency, idle FIFO with addr_pending=0: push at cycle t, popped at t+1, lcd_enable high at t+2. Issue-to-issue spacing is at least HOLD_CYCLES+1 cycles.
- After reset, the driver's own init holds busy=1; no command issues until busy drops. The first command is then set-address 0x080.
- cursor_col/cursor_line are registered and update in the cycle the command is selected.
- idle = (state==IDLE) && empty && !clr_pending && !addr_pending.

Decomposition:
- Package lcd_pkg:
  - Constants LCD_CMD_CLEAR=8'h01 and LCD_CMD_SET_DDRAM=8'h80, line-2 offset 8'h40, CHAR_NL=8'h0A, CHAR_CR=8'h0D.
  - FSM state enum feeder_state_t {IDLE, ISSUE, WAIT}.
  - Bus field positions RS_BIT=9, RW_BIT=8.
- Sub-module lcd_char_fifo: synchronous FIFO, DEPTH x 8, with full/empty/push/pop and synchronous active-high reset on the same clk/rst.

Test Plan:
- Reset, busy=1 for 100 cycles then 0 -> no lcd_enable while busy=1. First strobe carries lcd_bus=0x080, the next carries 0x241 for "A" (0x41). Spacing between the two strobes >= 1601 cycles.
- Push 17 chars "0123456789ABCDEF" + "G" -> 16 writes (0x230..0x246). Cursor then wraps to line 1 and the next command is set-address 0x0C0, followed by 0x247.
- Push 20 chars with busy=0 and no pops draining fast -> in_ready falls after 16 stored. The 17th is held until a pop; no byte is lost or duplicated.
- Push "H",0x0A,"I" -> commands in order: 0x248, 0x0C0, 0x249. The newline produces no bus write.
- clr_req pulsed twice during a WAIT -> exactly one 0x001 issued after the current hold. It is followed by >= 6001 cycles gap, then 0x080; queued chars resume.
- rst asserted during WAIT with 3 chars queued -> next cycle lcd_enable=0, lcd_bus=0, idle=0 then 1 once no pending, FIFO empty, cursor 0/0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, bus layout and FSM state type for the LCD text feeder.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] LCD_LINE2_OFFSET  = 8'h40;
    localparam logic [7:0] CHAR_NL           = 8'h0A;
    localparam logic [7:0] CHAR_CR           = 8'h0D;

    localparam int RS_BIT = 9;
    localparam int RW_BIT = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} feeder_state_t;

    // Set-DDRAM-address command for a cursor position on the 2x16 display.
    function automatic logic [9:0] ddram_cmd(input logic line, input logic [3:0] col);
        logic [7:0] addr;
        addr = LCD_CMD_SET_DDRAM | (line ? LCD_LINE2_OFFSET : 8'h00) | {4'h0, col};
        return {2'b00, addr};
    endfunction

endpackage

// File: rtl/lcd_text_feeder_if.sv
// Character stream in, LCD driver transaction handshake out.
interface lcd_text_feeder_if;

    logic [7:0] in_char;
    logic       in_valid;
    logic       in_ready;
    logic       busy;
    logic       lcd_enable;
    logic [9:0] lcd_bus;

    modport master (
        input  in_char, in_valid, busy,
        output in_ready, lcd_enable, lcd_bus
    );

    modport slave (
        output in_char, in_valid, busy,
        input  in_ready, lcd_enable, lcd_bus
    );

endinterface

// File: rtl/lcd_char_fifo.sv
// Synchronous DEPTH x 8 character FIFO; a push while full is dropped.
module lcd_char_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/lcd_text_feeder.sv
// Buffers characters, tracks the 2x16 cursor and feeds one LCD command per
// driver transaction, inserting set-address commands at wrap, newline and clear.
module lcd_text_feeder
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned HOLD_CYCLES = 1600,
    parameter int unsigned CLR_CYCLES  = 6000,
    parameter int unsigned CNT_W       = 14,
    parameter int unsigned COLS        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    lcd_text_feeder_if.master         lcd,
    input  logic                      clr_req,
    output logic [3:0]                cursor_col,
    output logic                      cursor_line,
    output logic                      idle
);

    feeder_state_t state_q, state_d;

    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             sel_cmd;
    logic             sel_clr;
    logic [9:0]       cmd;
    logic [9:0]       bus_q;
    logic             is_clr_q;
    logic             addr_pending_q;
    logic             clr_pending_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [3:0]       col_q;
    logic             line_q;

    lcd_char_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (lcd.in_valid),
        .wdata(lcd.in_char),
        .pop  (pop),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Command selection by priority: clear, pending address, then FIFO head.
    always_comb begin
        sel_cmd = 1'b0;
        sel_clr = 1'b0;
        pop     = 1'b0;
        cmd     = '0;
        if (state_q == IDLE && !lcd.busy) begin
            if (clr_pending_q) begin
                sel_cmd = 1'b1;
                sel_clr = 1'b1;
                cmd     = {2'b00, LCD_CMD_CLEAR};
            end else if (addr_pending_q) begin
                sel_cmd = 1'b1;
                cmd     = ddram_cmd(line_q, col_q);
            end else if (!fifo_empty) begin
                pop = 1'b1;
                if (fifo_rdata != CHAR_NL && fifo_rdata != CHAR_CR) begin
                    sel_cmd        = 1'b1;
                    cmd[RS_BIT]    = 1'b1;
                    cmd[RW_BIT]    = 1'b0;
                    cmd[7:0]       = fifo_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sel_cmd) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (hold_cnt_q == '0 && !lcd.busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lcd.lcd_enable = (state_q == ISSUE);
        lcd.lcd_bus    = bus_q;
        lcd.in_ready   = !fifo_full;
        cursor_col     = col_q;
        cursor_line    = line_q;
        idle           = (state_q == IDLE) && fifo_empty && !clr_pending_q && !addr_pending_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q          <= '0;
            is_clr_q       <= 1'b0;
            addr_pending_q <= 1'b1;
            clr_pending_q  <= 1'b0;
            hold_cnt_q     <= '0;
            col_q          <= '0;
            line_q         <= 1'b0;
        end else begin
            if (sel_cmd) begin
                bus_q    <= cmd;
                is_clr_q <= sel_clr;
            end
            // A request landing in the same cycle as the clear is kept for another clear.
            clr_pending_q <= (clr_pending_q && !sel_clr) || clr_req;

            if (state_q == ISSUE) begin
                hold_cnt_q <= is_clr_q ? CNT_W'(CLR_CYCLES - 1) : CNT_W'(HOLD_CYCLES - 1);
            end else if (state_q == WAIT && hold_cnt_q != '0) begin
                hold_cnt_q <= hold_cnt_q - 1'b1;
            end

            if (sel_clr) begin
                col_q          <= '0;
                line_q         <= 1'b0;
                addr_pending_q <= 1'b1;
            end else if (sel_cmd && addr_pending_q) begin
                addr_pending_q <= 1'b0;
            end else if (pop) begin
                if (fifo_rdata == CHAR_NL) begin
                    line_q         <= ~line_q;
                    col_q          <= '0;
                    addr_pending_q <= 1'b1;
                end else if (fifo_rdata == CHAR_CR) begin
                    col_q          <= '0;
                    addr_pending_q <= 1'b1;
                end else if (col_q == 4'(COLS - 1)) begin
                    col_q          <= '0;
                    line_q         <= ~line_q;
                    addr_pending_q <= 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_text_feeder.sv
// Directed plus randomized bench for lcd_text_feeder with a cycle-timed
// behavioural model of the command stream compared every cycle.
module tb_lcd_text_feeder;

    localparam int DEPTH = 16;
    localparam int HOLD  = 40;
    localparam int CLR   = 120;
    localparam int COLS  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_req = 1'b0;
    logic [3:0] cursor_col;
    logic       cursor_line;
    logic       idle;

    lcd_text_feeder_if ifc ();

    lcd_text_feeder #(
        .DEPTH      (DEPTH),
        .HOLD_CYCLES(HOLD),
        .CLR_CYCLES (CLR),
        .CNT_W      (8),
        .COLS       (COLS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lcd        (ifc),
        .clr_req    (clr_req),
        .cursor_col (cursor_col),
        .cursor_line(cursor_line),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model state: pending queue, cursor, flags, and the timing of the
    // current transaction (strobe cycle, earliest cycle the hold may end).
    logic [7:0] mq[$];
    int         m_col, m_line, m_strobe, m_release;
    bit         m_addr, m_clr, m_txn;
    logic [9:0] m_bus;
    int         n = 0;
    bit         chk_en = 0;

    logic [9:0] slog[$];
    int         scyc[$];
    logic [9:0] exq[$];

    task automatic model_reset();
        mq.delete();
        m_col = 0; m_line = 0; m_addr = 1; m_clr = 0; m_txn = 0;
        m_bus = '0; m_strobe = -1; m_release = 0;
    endtask

    task automatic model_select(input logic [9:0] c, input int hold);
        m_bus = c; m_txn = 1; m_strobe = n + 1; m_release = n + 1 + hold;
    endtask

    initial begin
        logic [7:0] c;
        bit acc;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("lcd_enable", 32'(ifc.lcd_enable), 32'(m_txn && n == m_strobe));
                check("lcd_bus", 32'(ifc.lcd_bus), 32'(m_bus));
                check("cursor_col", 32'(cursor_col), 32'(m_col));
                check("cursor_line", 32'(cursor_line), 32'(m_line));
                check("in_ready", 32'(ifc.in_ready), 32'(mq.size() < DEPTH));
                check("idle", 32'(idle), 32'(!m_txn && mq.size() == 0 && !m_clr && !m_addr));
                if (ifc.lcd_enable === 1'b1) begin
                    slog.push_back(ifc.lcd_bus);
                    scyc.push_back(n);
                end
            end
            if (rst === 1'b1) begin
                model_reset();
                chk_en = 1;
            end else if (chk_en) begin
                acc = (ifc.in_valid === 1'b1) && (mq.size() < DEPTH);
                if (!m_txn && ifc.busy === 1'b0) begin
                    if (m_clr) begin
                        model_select(10'h001, CLR);
                        m_clr = 0; m_col = 0; m_line = 0; m_addr = 1;
                    end else if (m_addr) begin
                        model_select(10'(128 + 64 * m_line + m_col), HOLD);
                        m_addr = 0;
                    end else if (mq.size() > 0) begin
                        c = mq.pop_front();
                        if (c == 8'h0A) begin
                            m_line = 1 - m_line; m_col = 0; m_addr = 1;
                        end else if (c == 8'h0D) begin
                            m_col = 0; m_addr = 1;
                        end else begin
                            model_select({2'b10, c}, HOLD);
                            if (m_col == COLS - 1) begin
                                m_col = 0; m_line = 1 - m_line; m_addr = 1;
                            end else begin
                                m_col++;
                            end
                        end
                    end
                end else if (m_txn && n >= m_release && ifc.busy === 1'b0) begin
                    m_txn = 0;
                end
                if (clr_req === 1'b1) m_clr = 1;
                if (acc) mq.push_back(ifc.in_char);
            end
            n++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] c);
        bit acc;
        int k;
        ifc.in_char = c;
        ifc.in_valid = 1'b1;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            acc = (ifc.in_ready === 1'b1);
            tick();
            if (acc) break;
        end
        if (k == 3000) check("push timeout", 0, 1);
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (idle === 1'b1) break;
        end
        if (k == 5000) check("idle timeout", 0, 1);
        tick();
    endtask

    task automatic wait_strobe();
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (ifc.lcd_enable === 1'b1) break;
        end
        if (k == 3000) check("strobe timeout", 0, 1);
        tick();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic expect_seq(input string name, input int mark);
        check({name, " count"}, 32'(slog.size() - mark), 32'(exq.size()));
        for (int i = 0; i < exq.size(); i++) begin
            if (mark + i < slog.size())
                check($sformatf("%s[%0d]", name, i), 32'(slog[mark + i]), 32'(exq[i]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int mark;
        string s;
        logic [7:0] ch;
        int r;

        ifc.in_char = '0;
        ifc.in_valid = 1'b0;
        ifc.busy = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state, then driver init holds busy high.
        @(negedge clk);
        check("rst lcd_enable", 32'(ifc.lcd_enable), 0);
        check("rst lcd_bus", 32'(ifc.lcd_bus), 0);
        check("rst cursor", 32'({cursor_line, cursor_col}), 0);
        check("rst in_ready", 32'(ifc.in_ready), 1);
        check("rst idle", 32'(idle), 0);
        tick();
        mark = slog.size();
        push_byte(8'h41);
        repeat (100) tick();
        check("no strobe while busy", 32'(slog.size() - mark), 0);
        ifc.busy = 1'b0;
        wait_idle();
        exq = '{10'h080, 10'h241};
        expect_seq("first cmds", mark);
        if (slog.size() >= mark + 2)
            check("first spacing", 32'(scyc[mark + 1] - scyc[mark] >= HOLD + 1), 1);

        // Line wrap after 16 characters.
        reset_dut();
        mark = slog.size();
        s = "0123456789ABCDEFG";
        for (int i = 0; i < s.len(); i++) push_byte(s[i]);
        wait_idle();
        exq = '{10'h080};
        for (int i = 0; i < 10; i++) exq.push_back(10'(10'h230 + i));
        for (int i = 0; i < 6; i++) exq.push_back(10'(10'h241 + i));
        exq.push_back(10'h0C0);
        exq.push_back(10'h247);
        expect_seq("wrap", mark);
        @(negedge clk);
        check("wrap cursor", 32'({cursor_line, cursor_col}), 32'({1'b1, 4'd1}));
        tick();

        // FIFO fills while the driver is busy; 17th byte held off.
        reset_dut();
        ifc.busy = 1'b1;
        mark = slog.size();
        for (int i = 0; i < 16; i++) push_byte(8'(8'h61 + i));
        ifc.in_char = 8'h71;
        ifc.in_valid = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        check("full in_ready", 32'(ifc.in_ready), 0);
        tick();
        ifc.busy = 1'b0;
        for (int i = 16; i < 20; i++) push_byte(8'(8'h61 + i));
        wait_idle();
        exq = '{10'h080};
        for (int i = 0; i < 16; i++) exq.push_back(10'(10'h261 + i));
        exq.push_back(10'h0C0);
        for (int i = 16; i < 20; i++) exq.push_back(10'(10'h261 + i));
        expect_seq("fill", mark);

        // Newline moves to line 1 with no bus write of its own.
        reset_dut();
        mark = slog.size();
        push_byte(8'h48);
        push_byte(8'h0A);
        push_byte(8'h49);
        wait_idle();
        exq = '{10'h080, 10'h248, 10'h0C0, 10'h249};
        expect_seq("newline", mark);

        // Two clear requests during a hold collapse into one clear.
        reset_dut();
        ifc.busy = 1'b1;
        push_byte(8'h58);
        push_byte(8'h59);
        mark = slog.size();
        ifc.busy = 1'b0;
        wait_strobe();
        tick();
        clr_req = 1'b1; tick(); clr_req = 1'b0; tick(); tick();
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        wait_idle();
        exq = '{10'h080, 10'h001, 10'h080, 10'h258, 10'h259};
        expect_seq("clear", mark);
        if (slog.size() >= mark + 3) begin
            check("pre-clear spacing", 32'(scyc[mark + 1] - scyc[mark] >= HOLD + 1), 1);
            check("clear spacing", 32'(scyc[mark + 2] - scyc[mark + 1] >= CLR + 1), 1);
        end

        // Reset during a hold with characters queued.
        reset_dut();
        push_byte(8'h50);
        push_byte(8'h51);
        push_byte(8'h52);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifc.busy = 1'b1;
        @(negedge clk);
        check("abort lcd_enable", 32'(ifc.lcd_enable), 0);
        check("abort lcd_bus", 32'(ifc.lcd_bus), 0);
        check("abort idle", 32'(idle), 0);
        check("abort cursor", 32'({cursor_line, cursor_col}), 0);
        check("abort in_ready", 32'(ifc.in_ready), 1);
        tick();
        mark = slog.size();
        repeat (20) tick();
        ifc.busy = 1'b0;
        wait_idle();
        exq = '{10'h080};
        expect_seq("abort", mark);

        // Randomized traffic, busy jitter and occasional clears.
        for (int i = 0; i < 4000; i++) begin
            ifc.busy = ($urandom_range(0, 9) < 3);
            ifc.in_valid = ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 9);
            if (r == 0) ch = 8'h0A;
            else if (r == 1) ch = 8'h0D;
            else ch = 8'($urandom_range(32, 126));
            ifc.in_char = ch;
            clr_req = ($urandom_range(0, 99) < 2);
            tick();
        end
        ifc.in_valid = 1'b0;
        clr_req = 1'b0;
        ifc.busy = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
